ahb_arbiter_rr: RTL and testbench

Parametrised, burst-aware round-robin AHB bus arbiter for NUM_MASTERS masters. It is the successor to the fixed 4-master arbiter and sits between the master request lines and the shared address/control mux; its Hmaster output drives that mux select. Added behaviour:
- fair rotating priority;
- grant held for the full length of a defined-length burst;
- bounded hold for undefined-length INCR bursts;
- locked-transfer support;
- parking on a default master.

---
 rtl/ahb_arbiter_rr.sv | 196 +++++++++++++++++++
 tb/tb_ahb_arbiter_rr.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_rr.sv
// Burst-aware round-robin AHB arbiter with lock support and parking.
// In: Hclk Hreset Hreq Hlock Hready Htrans Hburst; out: Hgrant Hmaster Hmastlock.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                   Hclk,
  input  logic                   Hreset,
  input  logic [NUM_MASTERS-1:0] Hreq,
  input  logic [NUM_MASTERS-1:0] Hlock,
  input  logic                   Hready,
  input  logic [1:0]             Htrans,
  input  logic [2:0]             Hburst,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [MW-1:0]          Hmaster,
  output logic                   Hmastlock
);

  localparam int CAP =
    (MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16;
  localparam int CW = $clog2(CAP + 1);

  localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;

  typedef enum logic {
    ARB,
    BURST
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_incr;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_master;
  logic                   r_lock;

  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_incr_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [MW-1:0]          w_master_nxt;
  logic                   w_lock_nxt;

  logic                   w_ho;
  logic                   w_sat;
  logic                   w_locked;
  logic [CW-1:0]          w_load;
  logic                   w_rr_hit;
  logic [MW-1:0]          w_rr_pick;
  int                     w_idx;

  assign Hgrant    = r_grant;
  assign Hmaster   = r_master;
  assign Hmastlock = r_lock;

  // Ownership is locked only while the owner both locks and requests.
  assign w_locked = Hlock[r_master] & Hreq[r_master];

  // Remaining SEQ beats after the opening NONSEQ.
  always_comb begin
    w_load = '0;
    unique case (Hburst)
      3'b001:        w_load = CW'(MAX_INCR_BEATS - 1);
      3'b010, 3'b011: w_load = CW'(3);
      3'b100, 3'b101: w_load = CW'(7);
      3'b110, 3'b111: w_load = CW'(15);
      default:       w_load = '0;
    endcase
  end

  // Rotating search from owner+1; the owner itself is
  // visited last, so it only wins when it is alone.
  always_comb begin
    w_rr_hit  = 1'b0;
    w_rr_pick = DEF;
    w_idx     = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = (int'(r_master) + i) % NUM_MASTERS;
      if (!w_rr_hit && Hreq[w_idx[MW-1:0]]) begin
        w_rr_hit  = 1'b1;
        w_rr_pick = w_idx[MW-1:0];
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state  <= ARB;
      r_cnt    <= '0;
      r_incr   <= 1'b0;
      r_grant  <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      r_master <= DEF;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_incr   <= w_incr_nxt;
      r_grant  <= w_grant_nxt;
      r_master <= w_master_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  // Next state and beat counter; Hready=0 freezes all.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_incr_nxt  = r_incr;
    w_ho        = 1'b0;
    w_sat       = 1'b0;
    if (Hready) begin
      unique case (r_state)
        ARB: begin
          if (Htrans == T_NONSEQ &&
              Hburst != B_SINGLE) begin
            w_state_nxt = BURST;
            w_cnt_nxt   = w_load;
            w_incr_nxt  = (Hburst == B_INCR);
          end else begin
            w_ho = 1'b1;
          end
        end
        BURST: begin
          unique case (Htrans)
            T_SEQ: begin
              if (r_cnt > CW'(1)) begin
                w_cnt_nxt = r_cnt - CW'(1);
              end else if (r_incr && w_locked) begin
                // Locked INCR runs past the cap.
                w_sat     = 1'b1;
                w_cnt_nxt = CW'(1);
              end else begin
                w_ho        = 1'b1;
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
              end
            end
            T_BUSY: begin
              w_cnt_nxt = r_cnt;
            end
            T_IDLE, T_NONSEQ: begin
              // Early termination: a NONSEQ here
              // never reopens a burst for the owner.
              w_ho        = 1'b1;
              w_state_nxt = ARB;
              w_cnt_nxt   = '0;
            end
            default: begin
              w_cnt_nxt = r_cnt;
            end
          endcase
        end
        default: begin
          w_state_nxt = ARB;
        end
      endcase
    end
  end

  // Next registered outputs; change only at handovers.
  always_comb begin
    w_master_nxt = r_master;
    w_lock_nxt   = r_lock;
    if (w_sat) begin
      w_lock_nxt = 1'b1;
    end else if (w_ho) begin
      if (w_locked) begin
        w_lock_nxt = 1'b1;
      end else begin
        w_lock_nxt   = 1'b0;
        w_master_nxt = w_rr_hit ? w_rr_pick : DEF;
      end
    end
    w_grant_nxt = NUM_MASTERS'(1) << w_master_nxt;
  end

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge Hclk) disable iff (Hreset)
    $onehot(Hgrant));
  a_match: assert property (
    @(posedge Hclk) disable iff (Hreset)
    Hgrant == (NUM_MASTERS'(1) << Hmaster));
`endif

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Scoreboard bench for ahb_arbiter_rr: directed cycles push
// expected outputs, a negedge monitor pops and compares.
module tb_ahb_arbiter_rr;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BY = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  localparam logic [2:0] SG  = 3'b000;
  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] I4  = 3'b011;
  localparam logic [2:0] I8  = 3'b101;
  localparam logic [2:0] I16 = 3'b111;

  localparam logic [3:0] F = 4'b1111;

  logic       Hclk;
  logic       Hreset;
  logic [3:0] Hreq;
  logic [3:0] Hlock;
  logic       Hready;
  logic [1:0] Htrans;
  logic [2:0] Hburst;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;
  logic       Hmastlock;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  ahb_arbiter_rr #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .MAX_INCR_BEATS(4)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .Hreq     (Hreq),
    .Hlock    (Hlock),
    .Hready   (Hready),
    .Htrans   (Htrans),
    .Hburst   (Hburst),
    .Hgrant   (Hgrant),
    .Hmaster  (Hmaster),
    .Hmastlock(Hmastlock)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  always @(negedge Hclk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks = checks + 3;
      if (Hgrant !== e.g) begin
        failures++;
        $display("FAIL grant cyc=%0d got=%b exp=%b",
                 cyc, Hgrant, e.g);
      end
      if (Hmaster !== e.m) begin
        failures++;
        $display("FAIL master cyc=%0d got=%0d exp=%0d",
                 cyc, Hmaster, e.m);
      end
      if (Hmastlock !== e.l) begin
        failures++;
        $display("FAIL mastlock cyc=%0d got=%b exp=%b",
                 cyc, Hmastlock, e.l);
      end
    end
  end

  task automatic step(
    input logic       rst,
    input logic [3:0] req,
    input logic [3:0] lk,
    input logic       rdy,
    input logic [1:0] tr,
    input logic [2:0] bu,
    input int         em,
    input logic       el
  );
    exp_t e;
    @(posedge Hclk);
    #1;
    cyc++;
    Hreset = rst;
    Hreq   = req;
    Hlock  = lk;
    Hready = rdy;
    Htrans = tr;
    Hburst = bu;
    e.m = 2'(em);
    e.g = 4'b0001 << em;
    e.l = el;
    q.push_back(e);
  endtask

  initial begin
    Hreset = 1'b1;
    Hreq   = '0;
    Hlock  = '0;
    Hready = 1'b1;
    Htrans = ID;
    Hburst = SG;

    repeat (3) step(1, 0, 0, 1, ID, SG, 0, 0);
    step(0, 0, 0, 1, ID, SG, 0, 0);
    step(0, 0, 0, 1, ID, SG, 0, 0);

    for (int m = 0; m < 4; m++) begin
      step(0, F, 0, 1, NS, I4, m, 0);
      repeat (3) step(0, F, 0, 1, SQ, I4, m, 0);
    end

    step(0, F, 0, 1, NS, I8, 0, 0);
    step(0, F, 0, 1, SQ, I8, 0, 0);
    step(0, F, 0, 0, SQ, I8, 0, 0);
    step(0, F, 0, 0, SQ, I8, 0, 0);
    step(0, F, 0, 1, SQ, I8, 0, 0);
    step(0, F, 0, 1, BY, I8, 0, 0);
    repeat (5) step(0, F, 0, 1, SQ, I8, 0, 0);

    step(0, F, 4'b0100, 1, NS, SG, 1, 0);
    step(0, F, 4'b0100, 1, NS, I4, 2, 0);
    repeat (3) step(0, F, 4'b0100, 1, SQ, I4, 2, 0);
    step(0, F, 4'b0100, 1, NS, I4, 2, 1);
    repeat (3) step(0, F, 4'b0100, 1, SQ, I4, 2, 1);
    step(0, F, 0, 1, NS, I4, 2, 1);
    repeat (3) step(0, F, 0, 1, SQ, I4, 2, 1);

    step(0, 4'b0011, 0, 1, ID, SG, 3, 0);
    step(0, 4'b0011, 0, 1, ID, SG, 0, 0);
    step(0, 4'b0011, 0, 1, NS, INC, 1, 0);
    repeat (3) step(0, 4'b0011, 0, 1, SQ, INC, 1, 0);
    step(0, 4'b0011, 0, 1, ID, SG, 0, 0);

    step(0, 4'b0011, 4'b0010, 1, NS, INC, 1, 0);
    repeat (3) step(0, 4'b0011, 4'b0010, 1, SQ, INC, 1, 0);
    repeat (3) step(0, 4'b0011, 4'b0010, 1, SQ, INC, 1, 1);
    step(0, 4'b0011, 4'b0010, 1, ID, SG, 1, 1);
    step(0, 4'b0011, 0, 1, ID, SG, 1, 1);
    step(0, 4'b0011, 0, 1, ID, SG, 0, 0);

    step(0, 4'b0011, 0, 1, NS, I16, 1, 0);
    step(0, 4'b0011, 0, 1, SQ, I16, 1, 0);
    repeat (3) step(0, 4'b0001, 0, 1, SQ, I16, 1, 0);
    step(0, 0, 0, 1, ID, SG, 1, 0);

    step(0, 4'b0010, 0, 1, ID, SG, 0, 0);
    step(0, 4'b0010, 0, 1, NS, I16, 1, 0);
    repeat (2) step(0, 4'b0010, 0, 1, SQ, I16, 1, 0);
    step(1, 4'b0010, 0, 1, SQ, I16, 0, 0);
    step(0, 4'b0010, 0, 1, SQ, I16, 0, 0);
    step(0, 4'b0010, 0, 1, ID, SG, 1, 0);
    step(0, 0, 0, 1, ID, SG, 1, 0);
    step(0, 0, 0, 1, ID, SG, 0, 0);

    repeat (2) @(negedge Hclk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
